// File: rtl/tone_pkg.sv
// Shared note enum, FSM state type and note period table for the tone detector.
package tone_pkg;

  typedef enum logic [2:0] {
    NOTE_C4, NOTE_D4, NOTE_E4, NOTE_F4, NOTE_G4, NOTE_A4, NOTE_B4, NOTE_C5
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MEASURE, ST_LOCKED
  } state_e;

  localparam int NUM_NOTES = 8;

  // Period in clock cycles of note idx, rounded to nearest; frequencies held in centi-hertz.
  function automatic logic [31:0] note_period(input longint unsigned clk_hz,
                                              input int unsigned idx);
    longint unsigned f;
    case (idx)
      0:       f = 64'd26163;
      1:       f = 64'd29366;
      2:       f = 64'd32963;
      3:       f = 64'd34923;
      4:       f = 64'd39200;
      5:       f = 64'd44000;
      6:       f = 64'd49388;
      default: f = 64'd52325;
    endcase
    return 32'((clk_hz * 64'd100 + f / 64'd2) / f);
  endfunction

endpackage

// File: rtl/tone_period_match.sv
// Combinational comparator of a measured period against the eight note windows.
module tone_period_match
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int          CNT_W     = 20,
  parameter int          TOL_SHIFT = 6
) (
  input  logic [CNT_W-1:0] count,
  output logic             match,
  output note_e            k
);

  logic [31:0]          cnt_ext;
  logic [NUM_NOTES-1:0] hit;

  assign cnt_ext = 32'(count);

  // Windows are disjoint for the default table, so at most one bit of hit is set.
  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_win
    localparam logic [31:0] P   = note_period(64'(CLK_HZ), 32'(i));
    localparam logic [31:0] TOL = P >> TOL_SHIFT;
    logic [31:0] diff;
    assign diff   = (cnt_ext >= P) ? (cnt_ext - P) : (P - cnt_ext);
    assign hit[i] = (diff <= TOL);
  end

  always_comb begin
    match = |hit;
    k     = NOTE_C4;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (hit[i]) k = note_e'(3'(i));
    end
  end

endmodule

// File: rtl/tone_detector.sv
// Measures the rising-edge period of tone_in and locks onto one of the notes C4..C5.
// Define TONE_DET_DUTY_EN to add the high_time output (high cycles of the last period).
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int          CNT_W     = 20,
  parameter int          MATCH_N   = 3,
  parameter int          TOL_SHIFT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tone_in,
  output logic             note_valid,
  output logic [2:0]       note_idx,
  output logic             note_change,
  output logic [CNT_W-1:0] period
`ifdef TONE_DET_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam int               MC_W    = $clog2(MATCH_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(MATCH_N);

  state_e           state, state_next;
  logic             sync1, sync2, sync_prev, rise;
  logic [CNT_W-1:0] count, period_q;
  logic [MC_W-1:0]  match_cnt, match_cnt_next;
  note_e            last_k, note_q, k;
  logic             match, timeout, edge_ev, lock_ev, change_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= tone_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

  tone_period_match #(
    .CLK_HZ   (CLK_HZ),
    .CNT_W    (CNT_W),
    .TOL_SHIFT(TOL_SHIFT)
  ) u_match (
    .count(count),
    .match(match),
    .k    (k)
  );

  assign timeout = (state != ST_IDLE) && (count == CNT_MAX);
  assign edge_ev = rise && (state != ST_IDLE) && !timeout;

  // Consecutive matches of the same note count up and saturate at the lock threshold.
  always_comb begin
    match_cnt_next = '0;
    if (match) begin
      if ((k == last_k) && (match_cnt != '0))
        match_cnt_next = (match_cnt >= MC_LOCK) ? MC_LOCK : match_cnt + MC_W'(1);
      else
        match_cnt_next = MC_W'(1);
    end
  end

  assign lock_ev = edge_ev && match && (match_cnt_next == MC_LOCK) &&
                   ((state == ST_MEASURE) || (k != note_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A matching period for another note drops the lock until that note has repeated enough.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (rise) state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (timeout)      state_next = ST_IDLE;
        else if (lock_ev) state_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (timeout) state_next = ST_IDLE;
        else if (edge_ev && !lock_ev && (!match || (k != note_q))) state_next = ST_MEASURE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    note_valid  = (state == ST_LOCKED);
    note_idx    = note_q;
    note_change = change_q;
    period      = period_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      match_cnt <= '0;
      last_k    <= NOTE_C4;
      note_q    <= NOTE_C4;
      change_q  <= 1'b0;
      period_q  <= '0;
    end else begin
      change_q <= lock_ev;
      if (state == ST_IDLE) begin
        match_cnt <= '0;
        if (rise) count <= CNT_W'(1);
      end else if (timeout) begin
        count     <= '0;
        match_cnt <= '0;
      end else if (rise) begin
        period_q  <= count;
        count     <= CNT_W'(1);
        match_cnt <= match_cnt_next;
        if (match)   last_k <= k;
        if (lock_ev) note_q <= k;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

`ifdef TONE_DET_DUTY_EN
  logic [CNT_W-1:0] high_cnt;

  // The rise cycle itself is high, so a new period starts counting at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_cnt  <= '0;
      high_time <= '0;
    end else if (rise) begin
      if (edge_ev) high_time <= high_cnt;
      high_cnt <= CNT_W'(1);
    end else if (sync2 && (high_cnt != CNT_MAX)) begin
      high_cnt <= high_cnt + 1'b1;
    end
  end
`endif

endmodule
